instr_fetch_unit: RTL and testbench

- Front end that produces the instruction stream consumed by the MIPS controller and datapath.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready interface.
- Buffers returned words in a small prefetch queue and presents the head instruction with a valid flag. The valid flag drives the controller's enable.
- Applies the controller's pcsel redirect when an instruction retires, flushing any wrong-path fetches.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, a small prefetch queue and pcsel redirects.
// Optional IFU_BYPASS_EN: a response into an empty, non-discarding queue is presented combinationally.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  input  logic        instr_ack,
  input  logic [1:0]  pcsel,
  input  logic [31:0] jr_target
);
  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic          r_run;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];

  logic          w_credit, w_hs, w_drop, w_accept, w_qempty, w_byp;
  logic          w_ret, w_redir, w_qpop, w_push;
  logic [31:0]   w_pc4, w_target;
  logic [CW-1:0] w_infl_next;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_credit       = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(QDEPTH);
  assign imem_req_valid = r_run & w_credit;
  assign imem_addr      = r_pc;
  assign w_hs           = imem_req_valid & imem_req_ready;
  assign w_qempty       = (r_count == '0);
  assign w_drop         = imem_rsp_valid & (r_discard != '0);
  // Non-stale responses always arrive in sequential order from the last redirect target.
  assign w_accept       = imem_rsp_valid & ~w_drop;

`ifdef IFU_BYPASS_EN
  assign w_byp = w_qempty & (r_discard == '0) & imem_rsp_valid;
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    instr_valid = ~w_qempty;
    instr       = w_qempty ? 32'h0 : r_q_instr[r_rd];
    instr_pc    = w_qempty ? 32'h0 : r_q_pc[r_rd];
    if (w_byp) begin
      instr_valid = 1'b1;
      instr       = imem_rsp_data;
      instr_pc    = r_rsp_pc;
    end
  end

  assign w_ret   = instr_ack & instr_valid;
  assign w_redir = w_ret & (pcsel != 2'b00);
  assign w_qpop  = w_ret & (pcsel == 2'b00) & ~w_qempty;
  // A bypassed word that retires this cycle never enters the queue.
  assign w_push  = w_accept & ~w_redir & ~(w_byp & w_ret);
  assign w_pc4   = instr_pc + 32'd4;

  always_comb begin
    w_target = jr_target;
    case (pcsel)
      2'b01:   w_target = w_pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      2'b10:   w_target = {w_pc4[31:28], instr[25:0], 2'b00};
      default: w_target = jr_target;
    endcase
  end

  assign w_infl_next = r_inflight + CW'(w_hs) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= PC_RESET;
      r_rsp_pc   <= PC_RESET;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_infl_next;
      if (w_redir) begin
        // Everything still outstanding after this edge is wrong-path.
        r_pc      <= w_target;
        r_rsp_pc  <= w_target;
        r_discard <= w_infl_next;
        r_count   <= '0;
        r_rd      <= '0;
        r_wr      <= '0;
      end else begin
        if (w_hs)     r_pc     <= r_pc + 32'd4;
        if (w_accept) r_rsp_pc <= r_rsp_pc + 32'd4;
        r_discard <= r_discard - CW'(w_drop);
        r_count   <= r_count + CW'(w_push) - CW'(w_qpop);
        if (w_push) r_wr <= f_inc(r_wr);
        if (w_qpop) r_rd <= f_inc(r_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr] <= imem_rsp_data;
      r_q_pc[r_wr]    <= r_rsp_pc;
    end
  end

  a_no_rsp_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_rsp_valid && (r_count == CW'(QDEPTH))));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!reset_n)
    r_inflight <= CW'(QDEPTH));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/retire stimulus checked against an architectural
// instruction-stream model, plus directed scenarios pinned with literal expectations.
module tb_instr_fetch_unit;
  localparam logic [31:0] PCR = 32'h0040_0000;
  localparam int QD = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic [1:0]  pcsel = 2'b00;
  logic [31:0] jr_target = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_RESET(PCR), .QDEPTH(QD)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .instr_ack(instr_ack), .pcsel(pcsel), .jr_target(jr_target)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];

  int checks = 0, errors = 0, cyc = 0, last_due = 0, retired = 0;
  logic [31:0] exp_pc = PCR;
  // stimulus knobs
  int p_ready = 100, p_ack = 100, lat_lo = 1, lat_hi = 1;
  logic force_en = 1'b1, trig_en = 1'b0, trig_any = 1'b0, trig_need_rsp = 1'b0;
  logic [1:0]  force_sel = 2'b00, trig_sel = 2'b00;
  logic [31:0] trig_pc = '0, force_jr = '0;
  // per-step observations
  int s_cyc;
  logic s_valid, s_hs, s_fire, s_reqv;
  logic [31:0] s_pc, s_instr, s_hs_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h0810_0010;
      32'h0040_0008: return 32'h1000_0003;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] tgt(input logic [1:0] sel, input logic [31:0] pc,
                                      input logic [31:0] w, input logic [31:0] jr);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = pc + 32'd4;
    off = {{14{w[15]}}, w[15:0], 2'b00};
    case (sel)
      2'b01:   return p4 + off;
      2'b10:   return {p4[31:28], w[25:0], 2'b00};
      default: return jr;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [1:0] sel;
    logic ack;
    logic [31:0] jr;
    int due;
    @(negedge clk);
    s_cyc = cyc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < p_ready);
    #1;
    s_valid = instr_valid; s_pc = instr_pc; s_instr = instr; s_reqv = imem_req_valid;
    if (instr_valid) begin
      chk("stream_pc", instr_pc, exp_pc);
      chk("stream_instr", instr, memfn(exp_pc));
    end
    s_fire = trig_en && instr_valid && (trig_any || instr_pc == trig_pc) &&
             (!trig_need_rsp || imem_rsp_valid);
    jr = {$urandom, 2'b00};
    if (s_fire) begin
      ack = 1'b1; sel = trig_sel; jr = force_jr;
    end else begin
      ack = ($urandom_range(99) < p_ack);
      if (force_en) sel = force_sel;
      else case ($urandom_range(9))
        7: sel = 2'b01;
        8: sel = 2'b10;
        9: sel = 2'b11;
        default: sel = 2'b00;
      endcase
    end
    instr_ack = ack; pcsel = sel; jr_target = jr;
    #1;
    s_hs = imem_req_valid && imem_req_ready;
    s_hs_addr = imem_addr;
    if (imem_rsp_valid) void'(mq.pop_front());
    if (s_hs) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_addr, due: due});
    end
    if (instr_valid && ack) begin
      retired++;
      exp_pc = (sel == 2'b00) ? exp_pc + 32'd4 : tgt(sel, exp_pc, memfn(exp_pc), jr);
    end
    checks++;
    if (mq.size() > QD) begin
      errors++;
      $display("FAIL outstanding actual=%0d required<=%0d", mq.size(), QD);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; instr_ack = 1'b0; pcsel = 2'b00; jr_target = '0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    mq.delete();
    exp_pc = PCR;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_due = cyc;
  endtask

  task automatic next_hs(input string name, input logic [31:0] exp);
    logic got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_hs) begin got = 1'b1; break; end
    end
    chk(name, got ? s_hs_addr : 32'hDEAD_DEAD, exp);
  endtask

  task automatic next_valid(input string name, input logic [31:0] exp);
    logic got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_valid) begin got = 1'b1; break; end
    end
    chk(name, got ? s_pc : 32'hDEAD_DEAD, exp);
  endtask

  task automatic wait_fire(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_fire) begin got = 1'b1; break; end
    end
    trig_en = 1'b0;
    chk(name, {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] addrs [3];
    int n_hs, first_hs, first_v;
    do_reset();

    // Streaming with 1-cycle memory and ack every cycle.
    n_hs = 0; first_hs = -1; first_v = -1;
    for (int i = 0; i < 40 && (n_hs < 3 || first_v < 0); i++) begin
      step();
      if (s_hs && n_hs < 3) begin
        addrs[n_hs] = s_hs_addr;
        if (n_hs == 0) first_hs = s_cyc;
        n_hs++;
      end
      if (s_valid && first_v < 0) first_v = s_cyc;
    end
    chk("seq_addr0", addrs[0], 32'h0040_0000);
    chk("seq_addr1", addrs[1], 32'h0040_0004);
    chk("seq_addr2", addrs[2], 32'h0040_0008);
`ifdef IFU_BYPASS_EN
    chk("first_latency", first_v - first_hs, 32'd1);
`else
    chk("first_latency", first_v - first_hs, 32'd2);
`endif

    // Stall: credit limit, then resume without loss or duplication.
    do_reset();
    p_ack = 0; n_hs = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_hs) n_hs++;
    end
    chk("stall_req_count", n_hs, QD);
    chk("stall_req_valid", {31'b0, s_reqv}, 32'd0);
    p_ack = 100;
    next_hs("resume_addr", 32'h0040_0008);
    repeat (10) step();

    // Taken branch at 0x00400008.
    do_reset();
    trig_en = 1'b1; trig_any = 1'b0; trig_need_rsp = 1'b0; trig_pc = 32'h0040_0008; trig_sel = 2'b01;
    wait_fire("br_fire");
    chk("br_head_instr", s_instr, 32'h1000_0003);
    next_valid("br_next_pc", 32'h0040_0018);
    repeat (6) step();

    // J at 0x00400000.
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h0040_0000; trig_sel = 2'b10;
    wait_fire("j_fire");
    next_hs("j_next_fetch", 32'h0040_0040);
    next_valid("j_next_pc", 32'h0040_0040);
    repeat (6) step();

    // JR while a response arrives in the redirect cycle.
    do_reset();
    trig_en = 1'b1; trig_any = 1'b1; trig_need_rsp = 1'b1; trig_sel = 2'b11;
    force_jr = 32'h0040_0100;
    wait_fire("jr_fire");
    trig_any = 1'b0; trig_need_rsp = 1'b0;
    next_valid("jr_next_pc", 32'h0040_0100);
    repeat (6) step();

    // Reset mid-operation with requests outstanding.
    do_reset();
    p_ack = 0; lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_valid) break;
    end
    chk("pre_reset_valid", {31'b0, s_valid}, 32'd1);
    do_reset();
    p_ack = 100; lat_lo = 1; lat_hi = 1;
    next_hs("post_reset_addr", 32'h0040_0000);
    repeat (6) step();

    // Randomized traffic against the stream model.
    do_reset();
    force_en = 1'b0; p_ready = 70; p_ack = 70; lat_lo = 1; lat_hi = 4;
    retired = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step();
    end
    chk("random_progress", {31'b0, retired >= 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
